// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM feeding a 2-entry
// in-order instruction FIFO, with redirect (jump) handling and stale-response discard.
module fetch_unit #(
    parameter int unsigned                ADDRESS_BITS = 16,
    parameter logic [ADDRESS_BITS-1:0]    BOOT_ADDR    = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    instr_req,
    output logic [ADDRESS_BITS-1:0] instr_addr,
    input  logic                    instr_gnt,
    input  logic                    instr_rvalid,
    input  logic [31:0]             instr_rdata,
    input  logic                    jump_en,
    input  logic [ADDRESS_BITS-1:0] target_pc,
    input  logic                    fetch_ready,
    output logic                    fetch_valid,
    output logic [ADDRESS_BITS-1:0] pc,
    output logic [31:0]             instruction,
    output logic [1:0]              fsm_state
);
    localparam logic [31:0]             NOP          = 32'h0000_0013;
    localparam logic [ADDRESS_BITS-1:0] BOOT_ALIGNED = {BOOT_ADDR[ADDRESS_BITS-1:2], 2'b00};
    localparam logic [ADDRESS_BITS-1:0] WORD_STEP    = ADDRESS_BITS'(4);

    // fsm_state encoding: 0 = IDLE, 1 = REQ, 2 = WAIT
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [ADDRESS_BITS-1:0] fetch_addr, fetch_addr_next;
    logic [ADDRESS_BITS-1:0] resp_pc;
    logic                    discard, discard_next;

    logic [ADDRESS_BITS-1:0] fifo_pc    [2];
    logic [31:0]             fifo_instr [2];
    logic                    rd_ptr, wr_ptr;
    logic [1:0]              count, count_after;

    logic                    granted, push, pop;
    logic [ADDRESS_BITS-1:0] jump_addr;

    // Handshakes: a memory request transfers on a cycle with instr_req && instr_gnt;
    // the head entry transfers to decode on a cycle with fetch_valid && fetch_ready.
    // A jump in the same cycle cancels both the pop and any incoming push.
    assign jump_addr   = {target_pc[ADDRESS_BITS-1:2], 2'b00};
    assign granted     = (state == REQ) && instr_gnt;
    assign push        = (state == WAIT) && instr_rvalid && !discard && !jump_en;
    assign pop         = fetch_valid && fetch_ready && !jump_en;
    assign count_after = count + 2'(push) - 2'(pop);

    always_comb begin
        state_next      = state;
        fetch_addr_next = fetch_addr;
        discard_next    = discard;

        case (state)
            IDLE: begin
                if (jump_en || (count < 2'd2)) state_next = REQ;
            end
            REQ: begin
                if (instr_gnt) state_next = WAIT;
            end
            WAIT: begin
                if (instr_rvalid) state_next = (jump_en || (count_after < 2'd2)) ? REQ : IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (jump_en) begin
            fetch_addr_next = jump_addr;
        end else if (granted) begin
            fetch_addr_next = fetch_addr + WORD_STEP;
        end

        // A response arriving clears the flag even if a jump lands on the same
        // cycle: that response is dropped by the push gating instead.
        if ((state == WAIT) && instr_rvalid) begin
            discard_next = 1'b0;
        end else if (jump_en && (granted || (state == WAIT))) begin
            discard_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_addr <= BOOT_ALIGNED;
            resp_pc    <= BOOT_ALIGNED;
            discard    <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_addr <= fetch_addr_next;
            discard    <= discard_next;
            if (granted) resp_pc <= fetch_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            count         <= 2'd0;
            fifo_pc[0]    <= '0;
            fifo_pc[1]    <= '0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
        end else if (jump_en) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= resp_pc;
                fifo_instr[wr_ptr] <= instr_rdata;
                wr_ptr             <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count_after;
        end
    end

    assign instr_req   = (state == REQ);
    assign instr_addr  = fetch_addr;
    assign fetch_valid = (count != 2'd0);
    assign pc          = fetch_valid ? fifo_pc[rd_ptr] : fetch_addr;
    assign instruction = fetch_valid ? fifo_instr[rd_ptr] : NOP;
    assign fsm_state   = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder model, in-order scoreboard
// of expected fetch PCs, directed redirect/backpressure/reset scenarios and a random phase.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int            AW   = 16;
    localparam logic [AW-1:0] BOOT = 16'hFFF8;
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    logic          clk;
    logic          rst_n;
    logic          instr_req;
    logic [AW-1:0] instr_addr;
    logic          instr_gnt    = 1'b0;
    logic          instr_rvalid = 1'b0;
    logic [31:0]   instr_rdata  = '0;
    logic          jump_en;
    logic [AW-1:0] target_pc;
    logic          fetch_ready;
    logic          fetch_valid;
    logic [AW-1:0] pc;
    logic [31:0]   instruction;
    logic [1:0]    fsm_state;

    fetch_unit #(.ADDRESS_BITS(AW), .BOOT_ADDR(BOOT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_req    (instr_req),
        .instr_addr   (instr_addr),
        .instr_gnt    (instr_gnt),
        .instr_rvalid (instr_rvalid),
        .instr_rdata  (instr_rdata),
        .jump_en      (jump_en),
        .target_pc    (target_pc),
        .fetch_ready  (fetch_ready),
        .fetch_valid  (fetch_valid),
        .pc           (pc),
        .instruction  (instruction),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int total;
    int bad;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // ---------------- scoreboard ----------------
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_pc;
    int            pop_count;

    task automatic load_expected(input logic [AW-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + AW'(4 * i));
    endtask

    always @(negedge clk) begin
        if (rst_n && fetch_valid && fetch_ready && !jump_en) begin
            pop_count++;
            check_val("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                check_val("sb_pc", pc, exp_pc);
                check_val("sb_instr", instruction, mem_word(exp_pc));
            end
        end
    end

    // ---------------- memory responder ----------------
    logic          gnt_rand;
    int            lat_min;
    int            lat_max;
    bit            pend;
    int            pend_cnt;
    logic [AW-1:0] pend_addr;
    bit            force_stray;
    int            grant_count;
    logic          prev_ungranted;
    logic [AW-1:0] prev_addr;
    logic          prev_jump;

    always @(negedge clk) begin
        instr_rvalid = 1'b0;
        instr_rdata  = '0;
        if (!rst_n) begin
            pend           = 1'b0;
            instr_gnt      = 1'b0;
            prev_ungranted = 1'b0;
        end else begin
            if (force_stray) begin
                instr_rvalid = 1'b1;
                instr_rdata  = 32'hDEAD_BEEF;
                force_stray  = 1'b0;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    instr_rvalid = 1'b1;
                    instr_rdata  = mem_word(pend_addr);
                    pend         = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            instr_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (instr_req) begin
                check_val("addr_align", 32'(instr_addr[1:0]), 0);
                if (prev_ungranted && !prev_jump) check_val("addr_stable", instr_addr, prev_addr);
            end
            if (instr_req && instr_gnt) begin
                pend      = 1'b1;
                pend_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
                pend_addr = instr_addr;
                grant_count++;
            end
            prev_ungranted = instr_req && !instr_gnt;
            prev_addr      = instr_addr;
            prev_jump      = jump_en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int start;
        int c;
        start = pop_count;
        c = 0;
        while ((pop_count - start) < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_val(tag, 32'((pop_count - start) >= n), 1);
    endtask

    task automatic wait_state(input logic [1:0] want, input int budget, input string tag);
        int c;
        c = 0;
        step();
        while (fsm_state != want && c < budget) begin
            step();
            c++;
        end
        check_val(tag, fsm_state, want);
    endtask

    task automatic wait_req(input int budget, input string tag, input logic [AW-1:0] want_addr);
        int c;
        c = 0;
        @(negedge clk);
        while (!instr_req && c < budget) begin
            @(negedge clk);
            c++;
        end
        check_val({tag, "_req"}, instr_req, 1);
        check_val(tag, instr_addr, want_addr);
    endtask

    // ---------------- main sequence ----------------
    int            g0;
    int            p0;
    logic [AW-1:0] t;

    initial begin
        total = 0; bad = 0; pop_count = 0; grant_count = 0;
        rst_n = 1'b0; jump_en = 1'b0; target_pc = '0; fetch_ready = 1'b0;
        gnt_rand = 1'b0; lat_min = 1; lat_max = 1; force_stray = 1'b0;
        pend = 1'b0; pend_cnt = 0; pend_addr = '0;
        prev_ungranted = 1'b0; prev_addr = '0; prev_jump = 1'b0;
        load_expected(BOOT);

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check_val("rst_req", instr_req, 0);
        check_val("rst_addr", instr_addr, BOOT);
        check_val("rst_valid", fetch_valid, 0);
        check_val("rst_instr", instruction, NOP);
        check_val("rst_pc", pc, BOOT);
        check_val("rst_state", fsm_state, 0);

        // Release and minimum latency; boot at 0xFFF8 exercises the wrap to 0x0000
        fetch_ready = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); check_val("c0_state", fsm_state, 0);
        @(negedge clk); check_val("c1_req", instr_req, 1);
                        check_val("c1_addr", instr_addr, BOOT);
        @(negedge clk); check_val("c2_valid", fetch_valid, 0);
                        check_val("c2_state", fsm_state, 2);
        @(negedge clk); check_val("c3_valid", fetch_valid, 1);
                        check_val("c3_pc", pc, BOOT);
        wait_pops(6, 40, "straight_drain");

        // Backpressure: fill, stall, release one slot
        step(); fetch_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check_val("bp_valid", fetch_valid, 1);
        check_val("bp_req", instr_req, 0);
        check_val("bp_state", fsm_state, 0);
        g0 = grant_count;
        step(); fetch_ready = 1'b1;
        step(); fetch_ready = 1'b0;
        repeat (8) step();
        check_val("bp_one_grant", grant_count - g0, 1);
        check_val("bp_req_after", instr_req, 0);
        check_val("bp_valid_after", fetch_valid, 1);

        // Redirect while waiting on a response
        fetch_ready = 1'b1; lat_min = 3; lat_max = 3;
        wait_state(2'd2, 40, "redir_in_wait");
        jump_en = 1'b1; target_pc = 16'h0102; load_expected(16'h0100);
        step(); jump_en = 1'b0;
        wait_req(20, "redir_addr", 16'h0100);
        wait_pops(4, 60, "redir_drain");

        // Redirect with a full FIFO and a simultaneous pop request
        lat_min = 1; lat_max = 1;
        step(); fetch_ready = 1'b0;
        repeat (12) step();
        @(negedge clk); check_val("full_valid", fetch_valid, 1);
        step();
        p0 = pop_count;
        fetch_ready = 1'b1; jump_en = 1'b1; target_pc = 16'h0000; load_expected(16'h0000);
        step(); jump_en = 1'b0;
        check_val("full_flush_valid", fetch_valid, 0);
        check_val("full_no_pop", pop_count - p0, 0);
        wait_pops(5, 40, "zero_seq");

        // Random grants, latencies, backpressure and redirects
        gnt_rand = 1'b1; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 400; i++) begin
            step();
            jump_en = 1'b0;
            fetch_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                t = AW'($urandom);
                jump_en = 1'b1;
                target_pc = t;
                load_expected({t[AW-1:2], 2'b00});
            end
        end
        step(); jump_en = 1'b0; gnt_rand = 1'b0; fetch_ready = 1'b1;
        wait_pops(3, 60, "rand_drain");

        // Asynchronous reset while a request is outstanding
        lat_min = 5; lat_max = 5;
        wait_state(2'd2, 40, "ar_in_wait");
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_req", instr_req, 0);
        check_val("ar_state", fsm_state, 0);
        check_val("ar_addr", instr_addr, BOOT);
        check_val("ar_valid", fetch_valid, 0);
        check_val("ar_instr", instruction, NOP);
        repeat (3) @(posedge clk);
        lat_min = 1; lat_max = 1;
        load_expected(BOOT);
        #1 rst_n = 1'b1; force_stray = 1'b1;
        wait_req(10, "post_rst_addr", BOOT);
        wait_pops(3, 40, "post_rst_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
